// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register.
//
// Captures the decoded control bundles, operands and register addresses each
// cycle and presents them to the execute stage. A control-unit flush becomes a
// bubble, a load-use hazard inserts a bubble and raises stall, and a downstream
// hold freezes the whole register. A flush requested during a hold is kept in
// flush_pend and turns into a single bubble on the first edge after the hold.
//
// Optional build macro: ID_EX_PERF_EN enables the saturating bubble counters.
// When undefined, perf_stall_cnt and perf_flush_cnt are tied to 0.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   id_valid .. id_imm     decoded instruction from the decode stage
//   id_flush               flush request from the control unit
//   ex_hold                execute/memory busy, freeze this register
//   stall                  freeze PC and IF/ID (combinational)
//   ex_valid .. ex_imm     registered copies presented to execute
//   perf_stall_cnt         hazard bubbles inserted (ID_EX_PERF_EN)
//   perf_flush_cnt         flush bubbles inserted (ID_EX_PERF_EN)

module id_ex_reg #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic [5:0]        id_exe,
  input  logic [5:0]        id_mem,
  input  logic [1:0]        id_wb,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_op_a,
  input  logic [DATA_W-1:0] id_op_b,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_flush,
  input  logic              ex_hold,
  output logic              stall,
  output logic              ex_valid,
  output logic [3:0]        ex_opcode,
  output logic [5:0]        ex_exe,
  output logic [5:0]        ex_mem,
  output logic [1:0]        ex_wb,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_flush_cnt
);

  logic flush_pend_q, flush_pend_d;
  logic load_in_ex;
  logic hazard;
  logic flush_eff;
  logic flush_bubble;
  logic haz_bubble;
  logic capture;

  // A load is recognised by its WB bundle: register write from memory.
  assign load_in_ex = ex_valid && (ex_wb == 2'b01);
  assign hazard     = load_in_ex && id_valid && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign flush_eff  = id_flush || flush_pend_q;

  // Per-edge priority: hold, then flush, then hazard, then normal capture.
  assign flush_bubble = !ex_hold && flush_eff;
  assign haz_bubble   = !ex_hold && !flush_eff && hazard;
  assign capture      = !ex_hold && !flush_eff && !hazard;

  // A flushed decode slot is discarded, so a coincident hazard needs no stall.
  assign stall = ex_hold || (hazard && !flush_eff);

  always_comb begin
    flush_pend_d = flush_pend_q;
    if (ex_hold) begin
      if (id_flush) flush_pend_d = 1'b1;
    end else if (flush_eff) begin
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend_q <= 1'b0;
    end else begin
      flush_pend_q <= flush_pend_d;
    end
  end

  // Bubbles zero every field, including the don't-care data/address fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_opcode <= '0;
      ex_exe    <= '0;
      ex_mem    <= '0;
      ex_wb     <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_op_a   <= '0;
      ex_op_b   <= '0;
      ex_imm    <= '0;
    end else if (flush_bubble || haz_bubble) begin
      ex_valid  <= 1'b0;
      ex_opcode <= '0;
      ex_exe    <= '0;
      ex_mem    <= '0;
      ex_wb     <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_op_a   <= '0;
      ex_op_b   <= '0;
      ex_imm    <= '0;
    end else if (capture) begin
      ex_valid  <= id_valid;
      ex_opcode <= id_opcode;
      ex_exe    <= id_exe;
      ex_mem    <= id_mem;
      ex_wb     <= id_wb;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      ex_rd     <= id_rd;
      ex_op_a   <= id_op_a;
      ex_op_b   <= id_op_b;
      ex_imm    <= id_imm;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (haz_bubble && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_bubble && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Testbench for id_ex_reg: directed vector table, reset sequences and a
// randomized run compared against a rule-level reference model.

module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [3:0]  opcode;
    logic [5:0]  exe;
    logic [5:0]  mem;
    logic [1:0]  wb;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
  } ex_t;

  typedef struct packed {
    ex_t  ins;
    logic flush;
    logic hold;
  } in_t;

  typedef struct {
    in_t        in;
    logic       exp_stall;
    logic       exp_valid;
    logic [5:0] exp_exe;
    logic [1:0] exp_wb;
    logic [3:0] exp_rd;
  } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  cur = '0;

  logic        stall;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [5:0]  ex_exe;
  logic [5:0]  ex_mem;
  logic [1:0]  ex_wb;
  logic [3:0]  ex_rs1, ex_rs2, ex_rd;
  logic [15:0] ex_op_a, ex_op_b, ex_imm;
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
  ex_t         dut_ex;

  int checks = 0;
  int failures = 0;

  // Reference model state
  ex_t m_ex;
  bit  m_pend;
  int  m_scnt, m_fcnt;

  row_t tbl[14];

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_W(16), .REG_AW(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (cur.ins.valid),
    .id_opcode     (cur.ins.opcode),
    .id_exe        (cur.ins.exe),
    .id_mem        (cur.ins.mem),
    .id_wb         (cur.ins.wb),
    .id_rs1        (cur.ins.rs1),
    .id_rs2        (cur.ins.rs2),
    .id_rd         (cur.ins.rd),
    .id_op_a       (cur.ins.a),
    .id_op_b       (cur.ins.b),
    .id_imm        (cur.ins.imm),
    .id_flush      (cur.flush),
    .ex_hold       (cur.hold),
    .stall         (stall),
    .ex_valid      (ex_valid),
    .ex_opcode     (ex_opcode),
    .ex_exe        (ex_exe),
    .ex_mem        (ex_mem),
    .ex_wb         (ex_wb),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .ex_op_a       (ex_op_a),
    .ex_op_b       (ex_op_b),
    .ex_imm        (ex_imm),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );

  assign dut_ex = {ex_valid, ex_opcode, ex_exe, ex_mem, ex_wb, ex_rs1, ex_rs2, ex_rd,
                   ex_op_a, ex_op_b, ex_imm};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic in_t mk(bit v, logic [3:0] op, logic [5:0] exe, logic [1:0] wb,
                             logic [3:0] rs1, logic [3:0] rs2, logic [3:0] rd, bit fl, bit hd);
    in_t r;
    r.ins.valid  = v;
    r.ins.opcode = op;
    r.ins.exe    = exe;
    r.ins.mem    = (wb == 2'b01) ? 6'b100000 : 6'b000000;
    r.ins.wb     = wb;
    r.ins.rs1    = rs1;
    r.ins.rs2    = rs2;
    r.ins.rd     = rd;
    r.ins.a      = {12'h0a0, rd};
    r.ins.b      = {12'h0b0, rs2};
    r.ins.imm    = {12'h1c0, op};
    r.flush      = fl;
    r.hold       = hd;
    return r;
  endfunction

  function automatic row_t row(in_t i, bit st, bit v, logic [5:0] e, logic [1:0] w,
                               logic [3:0] rd);
    row_t r;
    r.in = i; r.exp_stall = st; r.exp_valid = v; r.exp_exe = e; r.exp_wb = w; r.exp_rd = rd;
    return r;
  endfunction

  function automatic bit model_hazard();
    bit load_ex;
    load_ex = m_ex.valid && (m_ex.wb == 2'b01);
    return load_ex && cur.ins.valid && ((m_ex.rd == cur.ins.rs1) || (m_ex.rd == cur.ins.rs2));
  endfunction

  function automatic bit model_stall();
    return cur.hold || (model_hazard() && !(cur.flush || m_pend));
  endfunction

  // Advance the model by one clock edge using the inputs held across it.
  task automatic model_edge();
    bit haz, feff;
    haz  = model_hazard();
    feff = cur.flush || m_pend;
    if (cur.hold) begin
      if (cur.flush) m_pend = 1'b1;
    end else if (feff) begin
      m_ex = '0;
      m_pend = 1'b0;
      if (m_fcnt < 65535) m_fcnt++;
    end else if (haz) begin
      m_ex = '0;
      if (m_scnt < 65535) m_scnt++;
    end else begin
      m_ex = cur.ins;
    end
  endtask

  task automatic model_reset();
    m_ex = '0; m_pend = 1'b0; m_scnt = 0; m_fcnt = 0;
  endtask

  function automatic logic [15:0] exp_scnt();
`ifdef ID_EX_PERF_EN
    return 16'(m_scnt);
`else
    return 16'h0;
`endif
  endfunction

  function automatic logic [15:0] exp_fcnt();
`ifdef ID_EX_PERF_EN
    return 16'(m_fcnt);
`else
    return 16'h0;
`endif
  endfunction

  initial begin
    logic [15:0] tbl_scnt, tbl_fcnt;
    model_reset();

    // Directed table: LW=wb 01, ADD/ADDI=wb 11.
    tbl[0]  = row(mk(1, 4'h2, 6'b100001, 2'b01, 4'h1, 4'h0, 4'h3, 0, 0), 0, 1, 6'b100001, 2'b01, 4'h3);
    tbl[1]  = row(mk(1, 4'h1, 6'b000010, 2'b11, 4'h1, 4'h3, 4'h5, 0, 0), 1, 0, 6'b000000, 2'b00, 4'h0);
    tbl[2]  = row(mk(1, 4'h1, 6'b000010, 2'b11, 4'h1, 4'h3, 4'h5, 0, 0), 0, 1, 6'b000010, 2'b11, 4'h5);
    tbl[3]  = row(mk(1, 4'h2, 6'b100001, 2'b01, 4'h5, 4'h0, 4'h3, 0, 0), 0, 1, 6'b100001, 2'b01, 4'h3);
    tbl[4]  = row(mk(1, 4'h1, 6'b000010, 2'b11, 4'h1, 4'h2, 4'h4, 0, 0), 0, 1, 6'b000010, 2'b11, 4'h4);
    tbl[5]  = row(mk(1, 4'h3, 6'b100011, 2'b11, 4'h4, 4'h0, 4'h6, 1, 0), 0, 0, 6'b000000, 2'b00, 4'h0);
    tbl[6]  = row(mk(1, 4'h2, 6'b100001, 2'b01, 4'h1, 4'h0, 4'h3, 0, 0), 0, 1, 6'b100001, 2'b01, 4'h3);
    tbl[7]  = row(mk(1, 4'h1, 6'b000010, 2'b11, 4'h3, 4'h1, 4'h7, 1, 0), 0, 0, 6'b000000, 2'b00, 4'h0);
    tbl[8]  = row(mk(1, 4'h1, 6'b000101, 2'b11, 4'h1, 4'h2, 4'h8, 0, 0), 0, 1, 6'b000101, 2'b11, 4'h8);
    tbl[9]  = row(mk(1, 4'h9, 6'b001111, 2'b11, 4'h1, 4'h2, 4'h9, 0, 1), 1, 1, 6'b000101, 2'b11, 4'h8);
    tbl[10] = row(mk(1, 4'h9, 6'b001111, 2'b11, 4'h1, 4'h2, 4'h9, 1, 1), 1, 1, 6'b000101, 2'b11, 4'h8);
    tbl[11] = row(mk(1, 4'h9, 6'b001111, 2'b11, 4'h1, 4'h2, 4'h9, 0, 1), 1, 1, 6'b000101, 2'b11, 4'h8);
    tbl[12] = row(mk(1, 4'ha, 6'b000110, 2'b11, 4'h1, 4'h2, 4'ha, 0, 0), 0, 0, 6'b000000, 2'b00, 4'h0);
    tbl[13] = row(mk(1, 4'ha, 6'b000110, 2'b11, 4'h1, 4'h2, 4'ha, 0, 0), 0, 1, 6'b000110, 2'b11, 4'ha);

    // Reset state
    #12;
    chk("reset_ex", dut_ex, '0);
    chk("reset_stall", stall, 1'b0);
    chk("reset_cnt", {perf_stall_cnt, perf_flush_cnt}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      cur = tbl[i].in;
      #1;
      chk($sformatf("tbl%0d_stall", i), stall, tbl[i].exp_stall);
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("tbl%0d_ctl", i), {ex_valid, ex_exe, ex_wb, ex_rd},
          {tbl[i].exp_valid, tbl[i].exp_exe, tbl[i].exp_wb, tbl[i].exp_rd});
      chk($sformatf("tbl%0d_all", i), dut_ex, m_ex);
    end
`ifdef ID_EX_PERF_EN
    tbl_scnt = 16'd1;
    tbl_fcnt = 16'd3;
`else
    tbl_scnt = 16'd0;
    tbl_fcnt = 16'd0;
`endif
    chk("tbl_stall_cnt", perf_stall_cnt, tbl_scnt);
    chk("tbl_flush_cnt", perf_flush_cnt, tbl_fcnt);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      cur.ins.valid  = ($urandom_range(0, 3) != 0);
      cur.ins.opcode = 4'($urandom);
      cur.ins.exe    = 6'($urandom);
      cur.ins.mem    = 6'($urandom);
      cur.ins.wb     = 2'($urandom);
      cur.ins.rs1    = 4'($urandom_range(0, 3));
      cur.ins.rs2    = 4'($urandom_range(0, 3));
      cur.ins.rd     = 4'($urandom_range(0, 3));
      cur.ins.a      = 16'($urandom);
      cur.ins.b      = 16'($urandom);
      cur.ins.imm    = 16'($urandom);
      cur.flush      = ($urandom_range(0, 7) == 0);
      cur.hold       = ($urandom_range(0, 5) == 0);
      #1;
      chk("rnd_stall", stall, model_stall());
      @(posedge clk);
      model_edge();
      #1;
      chk("rnd_ex", dut_ex, m_ex);
      chk("rnd_cnt", {perf_stall_cnt, perf_flush_cnt}, {exp_scnt(), exp_fcnt()});
    end

    // Reset asserted mid-cycle with a valid instruction in ID
    cur = mk(1, 4'h1, 6'b010001, 2'b11, 4'h1, 4'h2, 4'h2, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_ex", dut_ex, '0);
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_cnt", {perf_stall_cnt, perf_flush_cnt}, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    model_edge();
    #1;
    chk("postrst_ctl", {ex_valid, ex_exe, ex_wb}, {1'b1, 6'b010001, 2'b11});
    chk("postrst_all", dut_ex, m_ex);

    // Reset during a hold with a pending flush discards the pending bubble
    cur = mk(1, 4'h1, 6'b000011, 2'b11, 4'h1, 4'h2, 4'h5, 1, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    cur.hold = 1'b0;
    cur.flush = 1'b0;
    #1;
    chk("rsthold_stall", stall, 1'b0);
    @(posedge clk); #1;
    chk("rsthold_capture", {ex_valid, ex_rd, ex_exe}, {1'b1, 4'h5, 6'b000011});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
